// File: rtl/apb_pkg.sv
// Shared APB definitions: default bus widths, timeout default and the requester state encoding.
// Imported by the requester, its wait timer and the memory wrapper slave.
package apb_pkg;

  localparam int APB_DATA_W          = 32;
  localparam int APB_ADDR_W          = 32;
  localparam int APB_TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_m_state_t;

  // Byte-lane count for a data bus of the given width.
  function automatic int strb_width(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/apb_master_if.sv
// APB bus between one requester and one responder.
// The master modport drives address/control/write data, the slave modport returns data and status.
interface apb_master_if #(
  parameter int ADDRESS_LENGTH = 32,
  parameter int DATA_LENGTH    = 32
);

  logic [ADDRESS_LENGTH-1:0] paddr;
  logic                      psel;
  logic                      penable;
  logic                      pwrite;
  logic [DATA_LENGTH-1:0]    pwdata;
  logic [DATA_LENGTH/8-1:0]  pstrb;
  logic [DATA_LENGTH-1:0]    prdata;
  logic                      pready;
  logic                      pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata, pstrb,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/apb_wait_timer.sv
// Counts ACCESS cycles spent without pready; flags the cycle that reaches TIMEOUT_CYCLES.
// Saturates at TIMEOUT_CYCLES so the count never wraps.
module apb_wait_timer #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int COUNT_W        = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic               from_top_clk,
  input  logic               preset,
  input  logic               clear,
  input  logic               enable,
  output logic [COUNT_W-1:0] count,
  output logic               expired
);

  localparam logic [COUNT_W-1:0] LAST_WAIT = COUNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [COUNT_W-1:0] MAX_WAIT  = COUNT_W'(TIMEOUT_CYCLES);

  always_ff @(posedge from_top_clk) begin
    if (preset || clear) begin
      count <= '0;
    end else if (enable && (count != MAX_WAIT)) begin
      count <= count + COUNT_W'(1);
    end
  end

  // The current enabled cycle is the TIMEOUT_CYCLES-th one without pready.
  assign expired = enable && (count == LAST_WAIT);

endmodule

// File: rtl/apb_master.sv
// APB requester: turns single-outstanding core load/store requests into SETUP/ACCESS transfers
// and returns a registered one-cycle response carrying read data and an error flag.
module apb_master
  import apb_pkg::*;
#(
  parameter int DATA_LENGTH    = APB_DATA_W,
  parameter int ADDRESS_LENGTH = APB_ADDR_W,
  parameter int TIMEOUT_CYCLES = APB_TIMEOUT_DEFAULT,
  parameter int COUNT_W        = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                      from_top_clk,
  input  logic                      preset,

  // Core request: a request is taken on a rising edge where from_core_req and
  // to_core_req_ready are both high; the core holds the request and its fields
  // stable until then. to_core_rsp_valid is a single-cycle pulse with no back-pressure.
  input  logic                      from_core_req,
  output logic                      to_core_req_ready,
  input  logic                      from_core_wr,
  input  logic [ADDRESS_LENGTH-1:0] from_core_addr,
  input  logic [DATA_LENGTH-1:0]    from_core_wdata,
  input  logic [DATA_LENGTH/8-1:0]  from_core_strb,
  output logic                      to_core_rsp_valid,
  output logic [DATA_LENGTH-1:0]    to_core_rdata,
  output logic                      to_core_rsp_err,

  apb_master_if.master              apb,

  output apb_m_state_t              dbg_state,
  output logic [COUNT_W-1:0]        dbg_wait_count
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  logic [1:0]                state_q;
  logic [1:0]                state_d;
  logic                      wr_q;
  logic [ADDRESS_LENGTH-1:0] addr_q;
  logic [DATA_LENGTH-1:0]    wdata_q;
  logic [DATA_LENGTH/8-1:0]  strb_q;
  logic                      rsp_valid_q;
  logic                      rsp_err_q;
  logic [DATA_LENGTH-1:0]    rdata_q;

  logic accept;
  logic in_access;
  logic xfer_done;
  logic xfer_abort;
  logic timer_en;
  logic timer_expired;

  assign to_core_req_ready = (state_q == ST_IDLE) && !preset;
  assign accept            = from_core_req && to_core_req_ready;
  assign in_access         = (state_q == ST_ACCESS);
  assign timer_en          = in_access && !apb.pready;
  assign xfer_done         = in_access && apb.pready;
  assign xfer_abort        = timer_expired;

  apb_wait_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .COUNT_W        (COUNT_W)
  ) u_wait_timer (
    .from_top_clk (from_top_clk),
    .preset       (preset),
    .clear        (accept),
    .enable       (timer_en),
    .count        (dbg_wait_count),
    .expired      (timer_expired)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: if (xfer_done || xfer_abort) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Request fields are captured once and drive the bus unchanged for the whole transfer.
  always_ff @(posedge from_top_clk) begin
    if (preset) begin
      state_q <= ST_IDLE;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        wr_q    <= from_core_wr;
        addr_q  <= from_core_addr;
        wdata_q <= from_core_wdata;
        strb_q  <= from_core_wr ? from_core_strb : '0;
      end
    end
  end

  // A read that times out returns zero data; writes never disturb the last read data.
  always_ff @(posedge from_top_clk) begin
    if (preset) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rdata_q     <= '0;
    end else begin
      rsp_valid_q <= xfer_done || xfer_abort;
      if (xfer_done) begin
        rsp_err_q <= apb.pslverr;
        if (!wr_q) rdata_q <= apb.prdata;
      end else if (xfer_abort) begin
        rsp_err_q <= 1'b1;
        if (!wr_q) rdata_q <= '0;
      end
    end
  end

  assign apb.psel    = (state_q != ST_IDLE);
  assign apb.penable = (state_q == ST_ACCESS);
  assign apb.pwrite  = wr_q;
  assign apb.paddr   = addr_q;
  assign apb.pwdata  = wdata_q;
  assign apb.pstrb   = strb_q;

  assign to_core_rsp_valid = rsp_valid_q;
  assign to_core_rsp_err   = rsp_err_q;
  assign to_core_rdata     = rdata_q;

  assign dbg_state = apb_m_state_t'(state_q);

endmodule
